// File: rtl/irq_pkg.sv
// Shared definitions for the hart-side interrupt receiver: mip bit positions,
// mcause exception codes and the request FSM state type.
package irq_pkg;

  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;
  localparam int MEI_BIT = 11;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    IN_TRAP = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer that brings an asynchronous level into the core
// clock domain; every stage clears on reset.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic synced
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the flop chain, oldest sample at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], level};
    end
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Hart-side interrupt receiver: registers mip from the CLINT lines and the
// synchronized external IRQ, gates it with mie/mstatus.MIE, selects one cause
// by fixed priority and hands it to the core over a req/ack handshake. No new
// request is raised until the handler retires mret.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            timer_irq_i,
  input  logic            software_irq_i,
  input  logic            ext_irq_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic            mstatus_mie_i,
  input  logic            mret_i,
  input  logic            irq_ack_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] mip_o
);

  logic            ext_synced;
  logic [XLEN-1:0] mip_next;
  logic [XLEN-1:0] mip_q;
  logic [XLEN-1:0] pend;
  logic            any_pend;
  logic [3:0]      win_code;
  logic            held_pending;
  logic            load_cause;
  logic            req_next;
  logic            req_q;
  logic [XLEN-1:0] cause_q;
  irq_state_e      state;
  irq_state_e      state_next;

  irq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .level  (ext_irq_i),
    .synced (ext_synced)
  );

  // Assemble the next mip value; only the three machine-level bits exist.
  always_comb begin
    mip_next          = '0;
    mip_next[MSI_BIT] = software_irq_i;
    mip_next[MTI_BIT] = timer_irq_i;
    mip_next[MEI_BIT] = ext_synced;
  end

  // mip follows its sources every cycle; nothing here makes a bit sticky.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mip_q <= '0;
    end else begin
      mip_q <= mip_next;
    end
  end

  assign pend     = mip_q & mie_i & {XLEN{mstatus_mie_i}};
  assign any_pend = |pend;

  // Fixed priority MEI > MSI > MTI, plus whether the latched cause is still live.
  always_comb begin
    win_code = CODE_MTI;
    if (pend[MEI_BIT]) begin
      win_code = CODE_MEI;
    end else if (pend[MSI_BIT]) begin
      win_code = CODE_MSI;
    end
    held_pending = 1'b0;
    case (cause_q[3:0])
      CODE_MEI: held_pending = pend[MEI_BIT];
      CODE_MSI: held_pending = pend[MSI_BIT];
      CODE_MTI: held_pending = pend[MTI_BIT];
      default:  held_pending = 1'b0;
    endcase
  end

  // Request FSM next state; ack beats withdrawal, stray ack/mret pulses are ignored.
  always_comb begin
    state_next = state;
    load_cause = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          state_next = REQ;
          load_cause = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_next = IN_TRAP;
        end else if (!held_pending) begin
          state_next = IDLE;
        end
      end
      IN_TRAP: begin
        if (mret_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    req_next = (state_next == REQ);
  end

  // State, request and cause registers; the cause only changes when a request is raised.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state <= state_next;
      req_q <= req_next;
      if (load_cause) begin
        cause_q <= {1'b1, {(XLEN-5){1'b0}}, win_code};
      end
    end
  end

  assign irq_req_o   = req_q;
  assign irq_cause_o = cause_q;
  assign mip_o       = mip_q;

endmodule
